// File: rtl/serial_cmp_driver_pkg.sv
// rtl/serial_cmp_driver_pkg.sv - shared state encoding and width bounds for serial_cmp_driver
package serial_cmp_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int W_MIN = 1;
  localparam int W_MAX = 32;

endpackage

// File: rtl/serial_cmp_driver.sv
// rtl/serial_cmp_driver.sv - drives a bit-serial comparator cell LSB-first and reports A>B / A==B
module serial_cmp_driver
  import serial_cmp_driver_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         x,
  output logic         y,
  output logic         v,
  input  logic         z,
  output logic         bit_valid,
  output logic         busy,
  output logic         done,
  output logic         gt,
  output logic         eq
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  if (W < W_MIN || W > W_MAX) begin : g_w_range_check
    $error("serial_cmp_driver: W out of legal range");
  end

  state_e        state_q, state_d;
  logic [W-1:0]  sha_q, sha_d;
  logic [W-1:0]  shb_q, shb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          v_q, v_d;
  logic          eq_run_q, eq_run_d;
  logic          gt_q, gt_d;
  logic          eq_q, eq_d;
  logic          bit_eq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sha_q    <= '0;
      shb_q    <= '0;
      cnt_q    <= '0;
      v_q      <= 1'b0;
      eq_run_q <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sha_q    <= sha_d;
      shb_q    <= shb_d;
      cnt_q    <= cnt_d;
      v_q      <= v_d;
      eq_run_q <= eq_run_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
    end
  end

  assign bit_eq = ~(sha_q[0] ^ shb_q[0]);

  // z comes back combinationally from the cell for the bit currently on x/y/v
  always_comb begin
    state_d  = state_q;
    sha_d    = sha_q;
    shb_d    = shb_q;
    cnt_d    = cnt_q;
    v_d      = v_q;
    eq_run_d = eq_run_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sha_d    = a;
          shb_d    = b;
          v_d      = 1'b0;
          eq_run_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        v_d      = z;
        eq_run_d = eq_run_q & bit_eq;
        sha_d    = sha_q >> 1;
        shb_d    = shb_q >> 1;
        if (cnt_q == CNT_LAST) begin
          gt_d    = z;
          eq_d    = eq_run_q & bit_eq;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Kept out of the FSM block so the path through the external cell stays acyclic
  assign bit_valid = (state_q == ST_SHIFT);
  assign x         = bit_valid & sha_q[0];
  assign y         = bit_valid & shb_q[0];
  assign v         = bit_valid & v_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign gt        = gt_q;
  assign eq        = eq_q;

endmodule

// File: tb/cmp_bit_cell.sv
// tb/cmp_bit_cell.sv - behavioural single-bit comparator cell for standalone runs
module cmp_bit_cell (
  input  logic x,
  input  logic y,
  input  logic v,
  output logic z
);
  assign z = (x & ~y) | (~(x ^ y) & v);
endmodule

// File: tb/tb_serial_cmp_driver.sv
// tb/tb_serial_cmp_driver.sv - self-checking bench for serial_cmp_driver at W=8 and W=1
module tb_serial_cmp_driver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         x, y, v, z, bit_valid, busy, done, gt, eq;

  logic         start1;
  logic [0:0]   a1, b1;
  logic         x1, y1, v1, z1, bit_valid1, busy1, done1, gt1, eq1;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       gt;
    logic       eq;
  } vec_t;

  vec_t tbl[9];
  vec_t tbl1[4];

  always #5 clk = ~clk;

  serial_cmp_driver #(.W(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .x(x), .y(y), .v(v), .z(z), .bit_valid(bit_valid),
    .busy(busy), .done(done), .gt(gt), .eq(eq)
  );
  cmp_bit_cell u_cell (.x(x), .y(y), .v(v), .z(z));

  serial_cmp_driver #(.W(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .x(x1), .y(y1), .v(v1), .z(z1), .bit_valid(bit_valid1),
    .busy(busy1), .done(done1), .gt(gt1), .eq(eq1)
  );
  cmp_bit_cell u_cell1 (.x(x1), .y(y1), .v(v1), .z(z1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Running "A>B so far" before bit i is just the unsigned compare of the low i bits
  function automatic logic v_model(input logic [7:0] pa, input logic [7:0] pb, input int i);
    logic [7:0] m;
    m = 8'((16'd1 << i) - 16'd1);
    return (pa & m) > (pb & m);
  endfunction

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic gt_e,
                        input logic eq_e, input string tag);
    start = 1'b1; a = ta; b = tb_;
    tick();
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    for (int i = 0; i < W; i++) begin
      check({tag, " bit_valid"}, bit_valid, 1'b1);
      check({tag, " busy"}, busy, 1'b1);
      check({tag, " done early"}, done, 1'b0);
      check({tag, " x"}, x, ta[i]);
      check({tag, " y"}, y, tb_[i]);
      check({tag, " v"}, v, v_model(ta, tb_, i));
      tick();
    end
    check({tag, " done"}, done, 1'b1);
    check({tag, " busy in done"}, busy, 1'b1);
    check({tag, " bit_valid off"}, bit_valid, 1'b0);
    check({tag, " gt"}, gt, gt_e);
    check({tag, " eq"}, eq, eq_e);
    tick();
    check({tag, " done pulse"}, done, 1'b0);
    check({tag, " idle"}, busy, 1'b0);
    check({tag, " gt hold"}, gt, gt_e);
    check({tag, " eq hold"}, eq, eq_e);
  endtask

  task automatic run_op1(input logic ta, input logic tb_, input logic gt_e, input logic eq_e);
    start1 = 1'b1; a1 = ta; b1 = tb_;
    tick();
    start1 = 1'b0; a1 = ~ta; b1 = ~tb_;
    check("w1 bit_valid", bit_valid1, 1'b1);
    check("w1 xy", {x1, y1}, {ta, tb_});
    check("w1 v", v1, 1'b0);
    check("w1 done early", done1, 1'b0);
    tick();
    check("w1 done", done1, 1'b1);
    check("w1 gt", gt1, gt_e);
    check("w1 eq", eq1, eq_e);
    tick();
    check("w1 idle", {busy1, done1}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h5A, 8'h3C, 1'b1, 1'b0};
    tbl[1] = '{8'hA5, 8'hA5, 1'b0, 1'b1};
    tbl[2] = '{8'h7F, 8'h80, 1'b0, 1'b0};
    tbl[3] = '{8'h01, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b0, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 1'b0, 1'b1};
    tbl[6] = '{8'h80, 8'h7F, 1'b1, 1'b0};
    tbl[7] = '{8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[8] = '{8'hFE, 8'hFF, 1'b0, 1'b0};
    tbl1[0] = '{8'h00, 8'h00, 1'b0, 1'b1};
    tbl1[1] = '{8'h01, 8'h00, 1'b1, 1'b0};
    tbl1[2] = '{8'h00, 8'h01, 1'b0, 1'b0};
    tbl1[3] = '{8'h01, 8'h01, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    #1;
    check("reset outputs", {x, y, v, bit_valid, busy, done, gt, eq}, 8'h00);
    check("reset outputs w1", {x1, y1, v1, bit_valid1, busy1, done1, gt1, eq1}, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle after reset", {busy, done, bit_valid}, 3'b000);

    for (int k = 0; k < 9; k++)
      run_op(tbl[k].a, tbl[k].b, tbl[k].gt, tbl[k].eq, $sformatf("tbl%0d", k));

    for (int k = 0; k < 40; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = (k % 5 == 0) ? ra : 8'($urandom);
      run_op(ra, rb, ra > rb, ra == rb, $sformatf("rnd%0d", k));
    end

    // Starts during SHIFT and DONE must be dropped without disturbing the operation
    start = 1'b1; a = 8'hFF; b = 8'h00;
    tick();
    start = 1'b0; a = 8'h00; b = 8'hFF;
    for (int i = 0; i < W; i++) begin
      start = (i == 3);
      check("busy-start x", x, 1'b1);
      check("busy-start y", y, 1'b0);
      check("busy-start done", done, 1'b0);
      tick();
    end
    start = 1'b1;
    check("busy-start done pulse", done, 1'b1);
    check("busy-start gt", gt, 1'b1);
    check("busy-start eq", eq, 1'b0);
    tick();
    start = 1'b0;
    check("done-start ignored", {busy, done}, 2'b00);
    run_op(8'h00, 8'hFF, 1'b0, 1'b0, "after-ignored");

    // Asynchronous reset in the middle of bit 4
    start = 1'b1; a = 8'h5A; b = 8'h3C;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre-reset bit_valid", bit_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async reset outputs", {x, y, v, bit_valid, busy, done, gt, eq}, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("no done after reset", {done, busy}, 2'b00);
    end
    check("gt/eq cleared", {gt, eq}, 2'b00);
    run_op(8'h5A, 8'h3C, 1'b1, 1'b0, "post-reset");

    for (int k = 0; k < 4; k++)
      run_op1(tbl1[k].a[0], tbl1[k].b[0], tbl1[k].gt, tbl1[k].eq);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_cmp_driver.md
Name: serial_cmp_driver

Overview:
- Driving end of the bit-serial comparator interface (x, y, v in; z out).
- Accepts two parallel W-bit words through a start/busy/done handshake, shifts them LSB-first into an external comparator cell, and feeds the cell's z back as the next bit's v.
- Presents the final A>B result and an internally tracked A==B flag.
- Sits between the parallel datapath and the existing single-bit comparator cell.

Parameters:
W, 8, operand width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  load request; sampled only in IDLE
a  input  W  operand A; captured on accepted start
b  input  W  operand B; captured on accepted start
x  output  1  current A bit to the cell (LSB first)
y  output  1  current B bit to the cell
v  output  1  running "A>B so far" into the cell
z  input  1  cell result, z = (x & ~y) | (~(x ^ y) & v)
bit_valid  output  1  high while x/y/v carry a live bit
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when gt/eq are updated
gt  output  1  registered result A > B (unsigned)
eq  output  1  registered result A == B

Behaviour:
- Reset, asserted asynchronously:
  - State goes to IDLE.
  - Shift registers, bit counter and v register clear to 0.
  - x, y, v, bit_valid, busy, done, gt and eq are all 0.
  - Reset mid-shift abandons the operation: no done pulse, gt/eq = 0.
- States: IDLE, SHIFT, DONE.
  - IDLE: start=1 at edge T0 captures a into sha and b into shb, clears v_reg to 0, sets eq_run to 1, sets cnt to 0, then goes to SHIFT.
  - SHIFT: outputs are combinational from the registers: x=sha[0], y=shb[0], v=v_reg, bit_valid=1.
    - Each edge: v_reg<=z; eq_run<=eq_run & ~(x^y); sha and shb shift right by one (zero fill); cnt<=cnt+1.
    - At the edge where cnt==W-1 (edge T0+W): gt<=z, eq<=eq_run & ~(x^y), then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: start accepted at T0; done is high in the cycle after edge T0+W; gt/eq are valid from that cycle on.
- Output holding:
  - gt/eq hold until the next operation's DONE update or reset.
  - They are not cleared on a new start.
- busy=1 from the edge after T0 through the DONE cycle inclusive.
- start while busy (SHIFT or DONE) is ignored, with no queuing. start in the DONE cycle is also ignored; the next accept is the first IDLE cycle.
- Outside SHIFT, x/y/v/bit_valid = 0.
- cnt width is clog2(W) with a minimum of 1 bit; it never wraps past W-1.
- W=1: a single SHIFT cycle; gt = a[0]&~b[0].
- Ordering: LSB-first with v initialised to 0 means higher bits override lower ones, giving a strict unsigned greater-than.
- z is consumed combinationally in the same cycle the bit is presented; the external cell must be purely combinational.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2, and the W legal-range bounds.
- No sub-module inside the RTL.
- The bench instantiates the existing comparator cell between x/y/v and z.
- A behavioural cell model named cmp_bit_cell lives in the verification tree for standalone runs.

Test Plan:
1. W=8, a=8'h5A, b=8'h3C, start pulse -> exactly 8 bit_valid cycles; x sequence 0,1,0,1,1,0,1,0; done one cycle later; gt=1, eq=0.
2. a=b=8'hA5 -> gt=0, eq=1; v stays 0 for all 8 bits.
3. a=8'h7F, b=8'h80 -> gt=0, eq=0 (MSB overrides); then a=8'h01, b=8'h00 -> gt=1 (LSB alone decides).
4. Start with a=8'hFF, b=8'h00, re-pulse start at SHIFT bit 3 and in the DONE cycle with other operands -> both ignored; one done, gt=1; next start in IDLE accepted normally.
5. Assert rst for 1 ns mid-cycle during SHIFT bit 4 -> all outputs 0 immediately; no done pulse; a following start completes correctly in W+1 cycles.
6. W=1 build: the four combinations of (a,b) -> gt=1 only for (1,0); eq=1 for (0,0) and (1,1); done at T0+2 every time.
